// File: rtl/obf_seq_ctrl_pkg.sv
// Shared types and parameter defaults for the obfuscation sequencer.
// Encodes the two sequencer states and the ppc/key widths used by obf_insngen.
package obf_seq_ctrl_pkg;

    localparam int OBF_PPC_WIDTH = 4;
    localparam int OBF_KEY_WIDTH = 8;

    typedef enum logic {
        OBF_SEQ_ST_IDLE  = 1'b0,
        OBF_SEQ_ST_ISSUE = 1'b1
    } seq_state_e;

endpackage

// File: rtl/obf_seq_ctrl.sv
// Sequencer between IF and ID: holds one reference insn, walks ppc through obf_insngen
// until the last generated insn, and registers each generated insn towards decode.
module obf_seq_ctrl
    import obf_seq_ctrl_pkg::*;
#(
    parameter int PPC_W = OBF_PPC_WIDTH,
    parameter int KEY_W = OBF_KEY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             obf_en_i,
    input  logic             key_we_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_insn_i,
    output logic             if_ready_o,
    input  logic             flush_i,
    output logic [31:0]      gen_ref_o,
    output logic [PPC_W-1:0] gen_ppc_o,
    output logic [KEY_W-1:0] gen_key_o,
    output logic             gen_en_o,
    input  logic [31:0]      gen_insn_i,
    input  logic             gen_last_i,
    input  logic             gen_skip_i,
    output logic             id_valid_o,
    output logic [31:0]      id_insn_o,
    input  logic             id_ready_i,
    output logic             busy_o,
    output logic             err_o
);

    seq_state_e       state_q, state_d;
    logic [31:0]      ref_q;
    logic             en_q;
    logic [PPC_W-1:0] ppc_q, ppc_d;
    logic [KEY_W-1:0] key_q, key_pend_q;
    logic             pend_q;
    logic             id_valid_q;
    logic [31:0]      id_insn_q;
    logic             err_q;

    logic             out_free;
    logic             accept;
    logic             step;
    logic             last_eff;
    logic             ovf;
    logic             key_apply;
    logic [PPC_W:0]   ppc_sum;

    assign out_free = !id_valid_q || id_ready_i;

    // ppc advance with saturation check: an extra top bit catches stepping past 2**PPC_W-1.
    always_comb begin
        ppc_sum  = {1'b0, ppc_q} + {{PPC_W{1'b0}}, 1'b1} + {{PPC_W{1'b0}}, gen_skip_i};
        ovf      = !gen_last_i && ppc_sum[PPC_W];
        last_eff = gen_last_i || ovf;
        ppc_d    = ppc_q;
        if (flush_i || accept) begin
            ppc_d = '0;
        end else if (step) begin
            ppc_d = ppc_sum[PPC_W-1:0];
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        if (!flush_i) begin
            unique case (state_q)
                OBF_SEQ_ST_IDLE: begin
                    if (if_valid_i) begin
                        accept  = 1'b1;
                        state_d = OBF_SEQ_ST_ISSUE;
                    end
                end
                OBF_SEQ_ST_ISSUE: begin
                    if (out_free) begin
                        step = 1'b1;
                        if (last_eff) begin
                            if (if_valid_i) begin
                                accept = 1'b1;
                            end else begin
                                state_d = OBF_SEQ_ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = OBF_SEQ_ST_IDLE;
            endcase
        end else begin
            state_d = OBF_SEQ_ST_IDLE;
        end
    end

    // A sequence boundary is the only point where a deferred key write may land.
    assign key_apply = (state_q == OBF_SEQ_ST_ISSUE) && ((state_d == OBF_SEQ_ST_IDLE) || accept);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OBF_SEQ_ST_IDLE;
            ref_q      <= '0;
            en_q       <= 1'b0;
            ppc_q      <= '0;
            key_q      <= '0;
            key_pend_q <= '0;
            pend_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_insn_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ppc_q   <= ppc_d;

            if (accept) begin
                ref_q <= if_insn_i;
                en_q  <= obf_en_i;
            end

            if (flush_i) begin
                id_valid_q <= 1'b0;
            end else if (step) begin
                id_valid_q <= 1'b1;
                id_insn_q  <= gen_insn_i;
            end else if (id_ready_i) begin
                id_valid_q <= 1'b0;
            end

            if (step && ovf) begin
                err_q <= 1'b1;
            end

            if (state_q == OBF_SEQ_ST_IDLE) begin
                if (key_we_i) begin
                    key_q <= key_i;
                end
            end else if (key_apply) begin
                if (key_we_i) begin
                    key_q <= key_i;
                end else if (pend_q) begin
                    key_q <= key_pend_q;
                end
                pend_q <= 1'b0;
            end else if (key_we_i) begin
                key_pend_q <= key_i;
                pend_q     <= 1'b1;
            end
        end
    end

    // Fetch must never see an accept while the core is held in reset.
    assign if_ready_o = rst_n && accept;
    assign busy_o     = (state_q == OBF_SEQ_ST_ISSUE);
    assign gen_ref_o  = ref_q;
    assign gen_ppc_o  = ppc_q;
    assign gen_key_o  = key_q;
    assign gen_en_o   = en_q;
    assign id_valid_o = id_valid_q;
    assign id_insn_o  = id_insn_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_obf_seq_ctrl.sv
// Directed bench for obf_seq_ctrl with a stub insn generator and an output scoreboard.
// Runs the sequencer with PPC_W = 2 so the overflow path is reachable in a few cycles.
module tb_obf_seq_ctrl;

    localparam int PPC_W = 2;
    localparam int KEY_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             obf_en;
    logic             key_we;
    logic [KEY_W-1:0] key_in;
    logic             if_valid;
    logic [31:0]      if_insn;
    logic             if_ready_o;
    logic             flush;
    logic [31:0]      gen_ref_o;
    logic [PPC_W-1:0] gen_ppc_o;
    logic [KEY_W-1:0] gen_key_o;
    logic             gen_en_o;
    logic [31:0]      gen_insn;
    logic             gen_last;
    logic             gen_skip;
    logic             id_valid_o;
    logic [31:0]      id_insn_o;
    logic             id_ready;
    logic             busy_o;
    logic             err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_cnt = 0;
    int last_ppc = 0;
    int skip_ppc = -1;

    logic [31:0] sb[$];
    int          out_cyc[$];

    always #5 clk = ~clk;

    obf_seq_ctrl #(.PPC_W(PPC_W), .KEY_W(KEY_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .obf_en_i   (obf_en),
        .key_we_i   (key_we),
        .key_i      (key_in),
        .if_valid_i (if_valid),
        .if_insn_i  (if_insn),
        .if_ready_o (if_ready_o),
        .flush_i    (flush),
        .gen_ref_o  (gen_ref_o),
        .gen_ppc_o  (gen_ppc_o),
        .gen_key_o  (gen_key_o),
        .gen_en_o   (gen_en_o),
        .gen_insn_i (gen_insn),
        .gen_last_i (gen_last),
        .gen_skip_i (gen_skip),
        .id_valid_o (id_valid_o),
        .id_insn_o  (id_insn_o),
        .id_ready_i (id_ready),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    function automatic logic [31:0] gfn(input logic [31:0] r, input int p, input logic [7:0] k);
        return r ^ {k, 8'h00, 8'(p * 17), 8'(p + 1)};
    endfunction

    // Stub generator: pass-through when disabled, otherwise last at last_ppc and skip at skip_ppc.
    assign gen_insn = gen_en_o ? gfn(gen_ref_o, int'(gen_ppc_o), gen_key_o) : gen_ref_o;
    assign gen_last = !gen_en_o || (int'(gen_ppc_o) >= last_ppc);
    assign gen_skip = gen_en_o && (int'(gen_ppc_o) == skip_ppc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (if_ready_o) ready_cnt++;
            if (id_valid_o && id_ready) begin
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    check("id_insn", id_insn_o, sb.pop_front());
                    out_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] insn, input logic en);
        int n = 0;
        if_valid = 1'b1;
        if_insn  = insn;
        obf_en   = en;
        while (n < 100) begin
            @(negedge clk);
            if (if_ready_o) break;
            n++;
        end
        check("accept_in_time", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy_o || id_valid_o) && n < 200) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < 200), 32'd1);
    endtask

    task automatic clear_logs();
        out_cyc.delete();
        ready_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cur_key;
        cur_key  = 8'h00;
        rst_n    = 1'b0;
        obf_en   = 1'b0;
        key_we   = 1'b0;
        key_in   = '0;
        if_valid = 1'b1;
        if_insn  = 32'hDEAD_BEEF;
        flush    = 1'b0;
        id_ready = 1'b1;

        // Reset state, with fetch offering an insn that must not be accepted.
        #12;
        check("rst_if_ready", 32'(if_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_id_valid", 32'(id_valid_o), 32'd0);
        check("rst_id_insn", id_insn_o, 32'h0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_ppc", 32'(gen_ppc_o), 32'd0);
        check("rst_key", 32'(gen_key_o), 32'd0);
        check("rst_ref", gen_ref_o, 32'h0);
        check("rst_en", 32'(gen_en_o), 32'd0);
        @(negedge clk);
        if_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Pass-through, two refs back to back.
        clear_logs();
        sb.push_back(32'hA000_000A);
        sb.push_back(32'hB000_000B);
        feed(32'hA000_000A, 1'b0);
        feed(32'hB000_000B, 1'b0);
        check("pt_ppc", 32'(gen_ppc_o), 32'd0);
        drain();
        check("pt_count", 32'(out_cyc.size()), 32'd2);
        if (out_cyc.size() == 2) check("pt_consecutive", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
        check("pt_ready_pulses", 32'(ready_cnt), 32'd2);

        // Three-step sequence, last at ppc 2.
        clear_logs();
        last_ppc = 2;
        skip_ppc = -1;
        for (int p = 0; p <= 2; p++) sb.push_back(gfn(32'h1234_5678, p, cur_key));
        feed(32'h1234_5678, 1'b1);
        drain();
        check("seq3_count", 32'(out_cyc.size()), 32'd3);
        if (out_cyc.size() == 3) check("seq3_span", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        check("seq3_ready_pulses", 32'(ready_cnt), 32'd1);

        // Skip at ppc 1: ppc walks 0, 1, 3.
        clear_logs();
        last_ppc = 3;
        skip_ppc = 1;
        sb.push_back(gfn(32'h0BAD_F00D, 0, cur_key));
        sb.push_back(gfn(32'h0BAD_F00D, 1, cur_key));
        sb.push_back(gfn(32'h0BAD_F00D, 3, cur_key));
        feed(32'h0BAD_F00D, 1'b1);
        drain();
        check("skip_count", 32'(out_cyc.size()), 32'd3);
        check("skip_no_err", 32'(err_o), 32'd0);

        // Decode stall of 3 cycles mid-sequence.
        clear_logs();
        skip_ppc = -1;
        for (int p = 0; p <= 3; p++) sb.push_back(gfn(32'hCAFE_0001, p, cur_key));
        feed(32'hCAFE_0001, 1'b1);
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_insn", id_insn_o, gfn(32'hCAFE_0001, 0, cur_key));
            check("stall_ppc", 32'(gen_ppc_o), 32'd1);
            check("stall_valid", 32'(id_valid_o), 32'd1);
        end
        tick();
        id_ready = 1'b1;
        drain();
        check("stall_count", 32'(out_cyc.size()), 32'd4);

        // Flush at ppc 2 of a 4-step sequence.
        clear_logs();
        sb.push_back(gfn(32'h5555_0005, 0, cur_key));
        sb.push_back(gfn(32'h5555_0005, 1, cur_key));
        feed(32'h5555_0005, 1'b1);
        tick();
        tick();
        flush    = 1'b1;
        if_valid = 1'b1;
        if_insn  = 32'h6666_0006;
        @(negedge clk);
        check("flush_at_ppc", 32'(gen_ppc_o), 32'd2);
        check("flush_if_ready", 32'(if_ready_o), 32'd0);
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        check("flush_id_valid", 32'(id_valid_o), 32'd0);
        check("flush_idle", 32'(busy_o), 32'd0);
        check("flush_ref_kept", gen_ref_o, 32'h5555_0005);
        sb.push_back(32'h6666_0006);
        feed(32'h6666_0006, 1'b0);
        check("post_flush_ppc", 32'(gen_ppc_o), 32'd0);
        check("post_flush_ref", gen_ref_o, 32'h6666_0006);
        drain();
        check("flush_count", 32'(out_cyc.size()), 32'd3);

        // Key write in IDLE lands at once.
        key_we = 1'b1;
        key_in = 8'h5A;
        tick();
        key_we = 1'b0;
        cur_key = 8'h5A;
        check("key_idle_write", 32'(gen_key_o), 32'h5A);

        // Overflow with no last, and a key write deferred to the sequence end.
        clear_logs();
        last_ppc = 99;
        for (int p = 0; p <= 3; p++) sb.push_back(gfn(32'h7777_0007, p, cur_key));
        feed(32'h7777_0007, 1'b1);
        tick();
        key_we = 1'b1;
        key_in = 8'hA5;
        tick();
        key_we = 1'b0;
        check("key_held_mid_seq", 32'(gen_key_o), 32'h5A);
        check("no_err_yet", 32'(err_o), 32'd0);
        drain();
        check("ovf_count", 32'(out_cyc.size()), 32'd4);
        check("ovf_err", 32'(err_o), 32'd1);
        check("key_after_seq", 32'(gen_key_o), 32'hA5);
        sb.push_back(32'h8888_0008);
        feed(32'h8888_0008, 1'b0);
        drain();
        repeat (3) tick();
        check("err_sticky", 32'(err_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
